// File: rtl/weight_load_pkg.sv
// Shared definitions for the weight loader: FSM state encoding, the clogb2
// width helper and the default kernel/bank counter widths.
package weight_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } wl_state_t;

  function automatic int clogb2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  localparam int KSIZE_MAX_DEF  = 16;
  localparam int BUFFER_NUM_DEF = 8;
  localparam int KCNT_W_DEF     = clogb2(KSIZE_MAX_DEF + 1);
  localparam int BCNT_W_DEF     = clogb2(BUFFER_NUM_DEF + 1);

endpackage

// File: rtl/weight_load_ctrl_addr_gen.sv
// Buffer write-address generator: nested bank / weight / word counters that
// advance once per accepted FIFO read.
module weight_addr_gen
  import weight_load_pkg::*;
#(
  parameter int ADDR_LEN   = 16,
  parameter int SINGLE_LEN = 24,
  parameter int KSIZE_MAX  = KSIZE_MAX_DEF,
  parameter int BUFFER_NUM = BUFFER_NUM_DEF,
  localparam int KCNT_W    = clogb2(KSIZE_MAX + 1),
  localparam int BCNT_W    = clogb2(BUFFER_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [SINGLE_LEN-1:0] weight_num,
  input  logic [KCNT_W-1:0]     kernel_words,
  input  logic [BCNT_W-1:0]     buffer_cnt,
  input  logic [ADDR_LEN-1:0]   st_addr,
  output logic [ADDR_LEN-1:0]   addr,
  output logic [BCNT_W-1:0]     bank,
  output logic                  last
);

  logic [KCNT_W-1:0]     k_cnt;
  logic [SINGLE_LEN-1:0] w_cnt;
  logic [ADDR_LEN-1:0]   w_base;
  logic                  k_end;
  logic                  w_end;
  logic                  b_end;

  assign k_end = (k_cnt == kernel_words - KCNT_W'(1));
  assign w_end = (w_cnt == weight_num - SINGLE_LEN'(1));
  assign b_end = (bank == buffer_cnt - BCNT_W'(1));

  // w_base tracks w*kernel_words incrementally so no multiplier is needed.
  assign addr = st_addr + w_base + ADDR_LEN'(k_cnt);
  assign last = k_end && w_end && b_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cnt  <= '0;
      w_cnt  <= '0;
      w_base <= '0;
      bank   <= '0;
    end else if (clr) begin
      k_cnt  <= '0;
      w_cnt  <= '0;
      w_base <= '0;
      bank   <= '0;
    end else if (adv) begin
      if (!k_end) begin
        k_cnt <= k_cnt + KCNT_W'(1);
      end else begin
        k_cnt <= '0;
        if (!w_end) begin
          w_cnt  <= w_cnt + SINGLE_LEN'(1);
          w_base <= w_base + ADDR_LEN'(kernel_words);
        end else begin
          w_cnt  <= '0;
          w_base <= '0;
          bank   <= bank + BCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// Weight loader: streams one layer's weights from the DDR read FIFO into the
// banked weight buffers. Define WFC_ERR_CHECK_EN to add the sticky err output.
//
// state     | meaning
// ST_IDLE   | waiting for conf
// ST_REQ    | ddr_conf pulse to the DDR read engine
// ST_STREAM | one FIFO read per non-empty cycle
// ST_DRAIN  | waiting for the last buffer write
// ST_DONE   | done pulse, back to idle
module weight_load_ctrl
  import weight_load_pkg::*;
#(
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 64,
  parameter int SINGLE_LEN   = 24,
  parameter int BUFFER_NUM   = 8,
  parameter int KSIZE_MAX    = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               conf,
  input  logic [SINGLE_LEN-1:0]              weight_num,
  input  logic [clogb2(KSIZE_MAX+1)-1:0]     kernel_words,
  input  logic [clogb2(BUFFER_NUM+1)-1:0]    buffer_cnt,
  input  logic [DDR_ADDR_LEN-1:0]            ddr_st_addr,
  input  logic [ADDR_LEN-1:0]                wb_st_addr,
  output logic [DDR_ADDR_LEN-1:0]            ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]              ddr_len,
  output logic                               ddr_conf,
  input  logic                               ddr_fifo_empty,
  output logic                               ddr_fifo_req,
  input  logic [DATA_LEN-1:0]                ddr_fifo_data,
  output logic [ADDR_LEN-1:0]                wb_addr,
  output logic [DATA_LEN-1:0]                wb_data,
  output logic [BUFFER_NUM-1:0]              wb_wea,
  output logic                               idle,
  output logic                               done
`ifdef WFC_ERR_CHECK_EN
  ,
  output logic                               err
`endif
);

  localparam int KCNT_W         = clogb2(KSIZE_MAX + 1);
  localparam int BCNT_W         = clogb2(BUFFER_NUM + 1);
  localparam int TOT_W          = SINGLE_LEN + KCNT_W + BCNT_W;
  localparam int BYTES_PER_WORD = DATA_LEN / 8;

  wl_state_t             state;
  logic [SINGLE_LEN-1:0] wn_q;
  logic [KCNT_W-1:0]     kw_q;
  logic [BCNT_W-1:0]     bc_q;
  logic [ADDR_LEN-1:0]   wb_st_q;
  logic [TOT_W-1:0]      rd_left;
  logic [TOT_W-1:0]      tot_words;
  logic [SINGLE_LEN-1:0] tot_bytes;
  logic                  cfg_bad;
  logic                  rd_fire;

  logic [ADDR_LEN-1:0]   ag_addr;
  logic [BCNT_W-1:0]     ag_bank;
  logic                  ag_last;

  logic                  wr_vld_p1;
  logic                  last_p1;
  logic                  last_p2;
  logic [ADDR_LEN-1:0]   addr_p1;
  logic [BCNT_W-1:0]     bank_p1;

  assign tot_words = TOT_W'(weight_num) * TOT_W'(kernel_words) * TOT_W'(buffer_cnt);
  assign tot_bytes = SINGLE_LEN'(tot_words * TOT_W'(BYTES_PER_WORD));

  assign cfg_bad = (weight_num == '0) || (kernel_words == '0) ||
                   (kernel_words > KCNT_W'(KSIZE_MAX)) ||
                   (buffer_cnt == '0) || (buffer_cnt > BCNT_W'(BUFFER_NUM));

  // rd_left is a guard against over-reading; the transition itself uses ag_last.
  assign rd_fire      = (state == ST_STREAM) && !ddr_fifo_empty && (rd_left != '0);
  assign ddr_fifo_req = rd_fire;

  weight_addr_gen #(
    .ADDR_LEN   (ADDR_LEN),
    .SINGLE_LEN (SINGLE_LEN),
    .KSIZE_MAX  (KSIZE_MAX),
    .BUFFER_NUM (BUFFER_NUM)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (state == ST_IDLE),
    .adv          (rd_fire),
    .weight_num   (wn_q),
    .kernel_words (kw_q),
    .buffer_cnt   (bc_q),
    .st_addr      (wb_st_q),
    .addr         (ag_addr),
    .bank         (ag_bank),
    .last         (ag_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      idle            <= 1'b1;
      done            <= 1'b0;
      ddr_conf        <= 1'b0;
      ddr_len         <= '0;
      ddr_st_addr_out <= '0;
      wn_q            <= '0;
      kw_q            <= '0;
      bc_q            <= '0;
      wb_st_q         <= '0;
      rd_left         <= '0;
    end else begin
      ddr_conf <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (conf) begin
            wn_q            <= weight_num;
            kw_q            <= kernel_words;
            bc_q            <= buffer_cnt;
            wb_st_q         <= wb_st_addr;
            ddr_st_addr_out <= ddr_st_addr;
            rd_left         <= tot_words;
            idle            <= 1'b0;
            if (cfg_bad) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_REQ;
              ddr_conf <= 1'b1;
              ddr_len  <= tot_bytes;
            end
          end
        end
        ST_REQ: state <= ST_STREAM;
        ST_STREAM: begin
          if (rd_fire) begin
            rd_left <= rd_left - TOT_W'(1);
            if (ag_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_p2) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          idle  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

  // Read at N: address captured at N+1 edge, FIFO data arrives in N+1, write visible at N+2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_p1 <= 1'b0;
      last_p1   <= 1'b0;
      last_p2   <= 1'b0;
      addr_p1   <= '0;
      bank_p1   <= '0;
      wb_addr   <= '0;
      wb_data   <= '0;
      wb_wea    <= '0;
    end else begin
      wr_vld_p1 <= rd_fire;
      last_p1   <= rd_fire && ag_last;
      last_p2   <= last_p1;
      if (rd_fire) begin
        addr_p1 <= ag_addr;
        bank_p1 <= ag_bank;
      end
      if (wr_vld_p1) begin
        wb_addr <= addr_p1;
        wb_data <= ddr_fifo_data;
        wb_wea  <= BUFFER_NUM'(1) << bank_p1;
      end else begin
        wb_wea  <= '0;
      end
    end
  end

`ifdef WFC_ERR_CHECK_EN
  // A busy-time conf sets err; in IDLE the new config decides set or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (conf) begin
      if (state != ST_IDLE) err <= 1'b1;
      else                  err <= cfg_bad;
    end
  end
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: directed configurations, a FIFO model
// and a write monitor that pops expected buffer writes from a queue.
`timescale 1ns/1ps
module tb_weight_load_ctrl;
  import weight_load_pkg::*;

  localparam int DDR_ADDR_LEN = 32;
  localparam int ADDR_LEN     = 16;
  localparam int DATA_LEN     = 64;
  localparam int SINGLE_LEN   = 24;
  localparam int BUFFER_NUM   = 8;
  localparam int KSIZE_MAX    = 16;
  localparam int KCNT_W       = clogb2(KSIZE_MAX + 1);
  localparam int BCNT_W       = clogb2(BUFFER_NUM + 1);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    conf = 1'b0;
  logic [SINGLE_LEN-1:0]   weight_num = '0;
  logic [KCNT_W-1:0]       kernel_words = '0;
  logic [BCNT_W-1:0]       buffer_cnt = '0;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr = '0;
  logic [ADDR_LEN-1:0]     wb_st_addr = '0;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   ddr_len;
  logic                    ddr_conf;
  logic                    ddr_fifo_empty;
  logic                    ddr_fifo_req;
  logic [DATA_LEN-1:0]     ddr_fifo_data;
  logic [ADDR_LEN-1:0]     wb_addr;
  logic [DATA_LEN-1:0]     wb_data;
  logic [BUFFER_NUM-1:0]   wb_wea;
  logic                    idle;
  logic                    done;
`ifdef WFC_ERR_CHECK_EN
  logic                    err;
`endif

  weight_load_ctrl #(
    .DDR_ADDR_LEN (DDR_ADDR_LEN),
    .ADDR_LEN     (ADDR_LEN),
    .DATA_LEN     (DATA_LEN),
    .SINGLE_LEN   (SINGLE_LEN),
    .BUFFER_NUM   (BUFFER_NUM),
    .KSIZE_MAX    (KSIZE_MAX)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .conf            (conf),
    .weight_num      (weight_num),
    .kernel_words    (kernel_words),
    .buffer_cnt      (buffer_cnt),
    .ddr_st_addr     (ddr_st_addr),
    .wb_st_addr      (wb_st_addr),
    .ddr_st_addr_out (ddr_st_addr_out),
    .ddr_len         (ddr_len),
    .ddr_conf        (ddr_conf),
    .ddr_fifo_empty  (ddr_fifo_empty),
    .ddr_fifo_req    (ddr_fifo_req),
    .ddr_fifo_data   (ddr_fifo_data),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .wb_wea          (wb_wea),
    .idle            (idle),
    .done            (done)
`ifdef WFC_ERR_CHECK_EN
    ,
    .err             (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_LEN-1:0]   addr;
    logic [DATA_LEN-1:0]   data;
    logic [BUFFER_NUM-1:0] wea;
  } wr_t;

  wr_t exp_q[$];
  int  nvec = 0;
  int  nerr = 0;
  int  cyc = 0;
  int  rd_idx = 0;
  int  last_rd_cyc = -1;
  int  conf_pulses = 0;
  bit  stall_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_LEN-1:0] word_of(input int idx);
    return 64'hC0DE_5A00_0000_0000 + 64'(idx) * 64'h0000_0001_0000_0101;
  endfunction

  // FIFO model: data for a read seen in cycle N is presented during N+1.
  initial begin
    bit pend;
    int pend_idx;
    pend = 1'b0;
    pend_idx = 0;
    ddr_fifo_empty = 1'b0;
    ddr_fifo_data  = '0;
    forever begin
      @(negedge clk);
      if (pend) ddr_fifo_data = word_of(pend_idx);
      ddr_fifo_empty = stall_mode ? ~ddr_fifo_empty : 1'b0;
      #1;
      pend = 1'b0;
      if (ddr_fifo_empty) chk("no_read_on_empty", ddr_fifo_req, 0);
      if (ddr_fifo_req) begin
        pend = 1'b1;
        pend_idx = rd_idx;
        rd_idx++;
        last_rd_cyc = cyc;
      end
    end
  end

  // Write monitor.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (ddr_conf === 1'b1) conf_pulses++;
      if (wb_wea !== '0) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_write: wea=%0h addr=%0h, expected no write", wb_wea, wb_addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(wb_addr), 64'(e.addr));
          chk("wr_data", wb_data, e.data);
          chk("wr_wea", 64'(wb_wea), 64'(e.wea));
        end
      end
    end
  end

  task automatic push_exp(input int wn, input int kw, input int bc, input logic [15:0] st);
    int n;
    n = rd_idx;
    for (int b = 0; b < bc; b++)
      for (int w = 0; w < wn; w++)
        for (int k = 0; k < kw; k++) begin
          wr_t e;
          e.addr = st + 16'(w * kw + k);
          e.data = word_of(n);
          e.wea  = 8'(1 << b);
          n++;
          exp_q.push_back(e);
        end
  endtask

  // Drives conf for one cycle (cycle C); returns at the negedge of C+1.
  task automatic start(input int wn, input int kw, input int bc,
                       input logic [31:0] da, input logic [15:0] st);
    @(negedge clk);
    weight_num   = SINGLE_LEN'(wn);
    kernel_words = KCNT_W'(kw);
    buffer_cnt   = BCNT_W'(bc);
    ddr_st_addr  = da;
    wb_st_addr   = st;
    conf         = 1'b1;
    @(negedge clk);
    conf         = 1'b0;
  endtask

  task automatic run_transfer(input string name, input int wn, input int kw, input int bc,
                              input logic [31:0] da, input logic [15:0] st,
                              input int exp_len, input int poke_at);
    int r0;
    int cp0;
    bit found;
    r0  = rd_idx;
    cp0 = conf_pulses;
    push_exp(wn, kw, bc, st);
    start(wn, kw, bc, da, st);
    chk({name, "_ddr_conf"}, ddr_conf, 1);
    chk({name, "_idle_low"}, idle, 0);
    @(negedge clk);
    chk({name, "_ddr_conf_1cyc"}, ddr_conf, 0);
    chk({name, "_ddr_len"}, 64'(ddr_len), 64'(exp_len));
    chk({name, "_ddr_addr"}, 64'(ddr_st_addr_out), 64'(da));
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == poke_at) begin
        weight_num  = 24'd7;
        ddr_st_addr = 32'hDEAD_0000;
        conf        = 1'b1;
      end else begin
        conf        = 1'b0;
      end
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    conf = 1'b0;
    chk({name, "_done_seen"}, found, 1);
    if (found) begin
      chk({name, "_done_latency"}, 64'(cyc - last_rd_cyc), 64'd3);
      chk({name, "_idle_at_done"}, idle, 0);
    end
    chk({name, "_reads"}, 64'(rd_idx - r0), 64'(wn * kw * bc));
    chk({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_addr_held"}, 64'(ddr_st_addr_out), 64'(da));
    @(negedge clk);
    chk({name, "_done_1cyc"}, done, 0);
    chk({name, "_idle_back"}, idle, 1);
    chk({name, "_conf_pulses"}, 64'(conf_pulses - cp0), 64'd1);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_idle"}, idle, 1);
    chk({name, "_ddr_addr"}, 64'(ddr_st_addr_out), 0);
    chk({name, "_ddr_len"}, 64'(ddr_len), 0);
    chk({name, "_ddr_conf"}, ddr_conf, 0);
    chk({name, "_fifo_req"}, ddr_fifo_req, 0);
    chk({name, "_wb_addr"}, 64'(wb_addr), 0);
    chk({name, "_wb_data"}, wb_data, 0);
    chk({name, "_wb_wea"}, 64'(wb_wea), 0);
    chk({name, "_done"}, done, 0);
`ifdef WFC_ERR_CHECK_EN
    chk({name, "_err"}, err, 0);
`endif
  endtask

  // Degenerate configurations: weight_num, kernel_words, buffer_cnt.
  int degen_tab[5][3] = '{'{0, 9, 2}, '{2, 0, 2}, '{2, 9, 0}, '{2, 17, 2}, '{2, 9, 9}};

  initial begin
    int r0;
    int cp0;
    #2 rst_n = 1'b0;
    #10;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", idle, 1);

    stall_mode = 1'b0;
    run_transfer("t1_nostall", 2, 9, 2, 32'h8000_0000, 16'h0010, 288, -1);

    stall_mode = 1'b1;
    run_transfer("t2_stall", 2, 9, 2, 32'h8000_1000, 16'h0010, 288, -1);
    stall_mode = 1'b0;

    run_transfer("t3_wrap", 4, 1, 1, 32'h0000_0040, 16'hFFFE, 32, -1);

    foreach (degen_tab[i]) begin
      r0  = rd_idx;
      cp0 = conf_pulses;
      start(degen_tab[i][0], degen_tab[i][1], degen_tab[i][2], 32'h1234_0000, 16'h0000);
      chk("degen_done", done, 1);
      chk("degen_no_ddr_conf", ddr_conf, 0);
      chk("degen_idle_low", idle, 0);
`ifdef WFC_ERR_CHECK_EN
      chk("degen_err", err, 1);
`endif
      @(negedge clk);
      chk("degen_done_1cyc", done, 0);
      chk("degen_idle_back", idle, 1);
      chk("degen_no_reads", 64'(rd_idx - r0), 0);
      chk("degen_conf_pulses", 64'(conf_pulses - cp0), 0);
    end

    run_transfer("t4_after_degen", 1, 2, 3, 32'h0000_2000, 16'h0100, 48, -1);
`ifdef WFC_ERR_CHECK_EN
    chk("err_cleared", err, 0);
`endif

    run_transfer("t5_busy_conf", 2, 9, 2, 32'h4000_0000, 16'h0010, 288, 10);
`ifdef WFC_ERR_CHECK_EN
    chk("busy_conf_err", err, 1);
`endif

    push_exp(2, 9, 2, 16'h0010);
    start(2, 9, 2, 32'h5555_0000, 16'h0010);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_transfer("t6_after_reset", 4, 1, 1, 32'h0000_0080, 16'hFFFE, 32, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
